qpsk_tx_shaper: RTL
===================

Name: qpsk_tx_shaper

Overview:
- QPSK transmitter front end, the counterpart of the receiver equalizer chain.
- Generates independent PRBS9 bit streams for I and Q and maps each bit to a ±1 symbol.
- Upsamples by OS and pulse-shapes with a polyphase FIR (RRC coefficients). The FIR is multiplier-free because symbols are ±1.
- Drives the channel model / DAC path. Also exports symbol bits and a strobe so the BER checker can align after the receiver slicer.

Parameters:
- OS, 4, oversampling factor; must divide NUM_TAPS.
- NUM_TAPS, 24, FIR length in OS-rate samples; branch length L = NUM_TAPS/OS.
- NBT_COEF, 8, coefficient total bits (signed).
- NBF_COEF, 7, coefficient fractional bits.
- COEFS, RRC set (roll-off 0.5), packed NUM_TAPS*NBT_COEF vector; coef[j] = COEFS[j*NBT_COEF +: NBT_COEF].
- NBT_OUT, 8, output total bits.
- NBF_OUT, 7, output fractional bits.
- SEED_I, 9'h1AA, I-branch PRBS9 seed (nonzero).
- SEED_Q, 9'h1FE, Q-branch PRBS9 seed (nonzero).

Ports:
- clk  in  1  system clock, one OS-rate sample per enabled cycle.
- i_reset  in  1  synchronous, active-high reset.
- i_en_tx  in  1  global enable; when low, all state freezes.
- o_os_data_I  out  NBT_OUT  shaped I sample, signed S(NBT_OUT,NBF_OUT).
- o_os_data_Q  out  NBT_OUT  shaped Q sample.
- o_sym_I  out  1  last inserted I bit (0 -> +1, 1 -> -1).
- o_sym_Q  out  1  last inserted Q bit.
- o_sym_valid  out  1  one-cycle strobe: new symbol inserted.
- o_phase  out  log2(OS)  current polyphase index.

Behaviour:
- Reset (synchronous, wins over i_en_tx):
  - LFSRs load SEED_I / SEED_Q; phase counter ph = 0.
  - Symbol shift registers and their valid masks (L entries each) cleared.
  - All outputs 0.
- PRBS9: polynomial x^9+x^5+1. Output bit = lfsr[8]. Step: lfsr <= {lfsr[7:0], lfsr[8]^lfsr[4]}. Steps only on symbol insertion.
- Phase counter: on each enabled edge, ph <= (ph==OS-1) ? 0 : ph+1.
- Insertion (enabled edge with pre-edge ph==OS-1), per branch:
  - Shift sym[k] <= sym[k-1] and valid[k] <= valid[k-1].
  - sym[0] <= PRBS bit, valid[0] <= 1; LFSR steps.
  - Next cycle: o_sym_valid = 1 and o_sym_I/Q = the inserted bit; o_sym_I/Q hold until the next insertion.
- FIR: on every enabled edge, o_os_data <= sat( Σ_{k=0..L-1} c_k ) using pre-edge state.
  - c_k = +coef[k*OS+ph] if valid[k] && sym[k]==0.
  - c_k = −coef[k*OS+ph] if valid[k] && sym[k]==1.
  - c_k = 0 if !valid[k].
- Arithmetic width: accumulator NBT_COEF+clog2(L)+1 bits, full precision. Align to NBF_OUT by truncation (drop LSBs) or sign-extension.
- Saturation: result saturates symmetrically to [−(2^(NBT_OUT−1)−1), 2^(NBT_OUT−1)−1]; −2^(NBT_OUT−1) is never emitted.
- Latency: first symbol inserted on the 4th enabled edge after reset. Its branch-0 contribution appears on the 5th edge; branch-k contribution appears k*OS edges later.
- Startup: invalid taps contribute 0, so there is no startup transient from stale data.
- i_en_tx low: outputs, ph, LFSR and sym regs hold; o_sym_valid forced 0.
- Reset mid-stream: full restart; the PRBS sequence repeats from the seed.
- I and Q use identical control; only data/seed differ.

Optional Feature:
- Macro: TX_PREAMBLE_EN.
- Defined: after reset, the first 16 inserted symbols per branch are an alternating preamble (I: 0,1,0,1…; Q: 0,0,1,1,…). The LFSRs do not step during the preamble. PRBS starts at symbol 17 from the seed. A 5-bit preamble counter clears on reset and saturates at 16.
- Undefined: PRBS from the first symbol; no counter logic present.

Test Plan:
- Reset, i_en_tx=1, default seeds, 40 edges -> o_sym_valid pulses every 4 cycles (first after edge 4); first I bits 1,1,0,1,0,1,0,1,0; first Q bits match the Q seed MSB-first (1,1,1,1,1,1,1,1,0); matches golden PRBS9 model for 1022 symbols.
- COEFS all zero except coef[5]=8'h40 -> o_os_data_I = 8'hC0 (−0.5) after edge 10, 0 on edges 11–13; pulse repeats every 4 edges with value ±0.5 tracking sym[1].
- All COEFS = 8'h7F (OS=4, L=6), sustained equal symbols -> accumulator 6*127 saturates to 8'h7F or 8'h81, never 8'h80.
- Toggle i_en_tx low for 7 cycles mid-stream -> all outputs, o_phase and sequence frozen; resumes without skipping or repeating symbols.
- Assert i_reset at phase 2 mid-stream -> next cycle all outputs 0, o_phase=0; PRBS restarts at the seed.
- With TX_PREAMBLE_EN: first 16 o_sym_I = 0,1,0,1…; symbol 17 equals the first PRBS bit (1); the undefined build gives PRBS from symbol 1.

Source files
------------

// File: rtl/qpsk_tx_shaper_if.sv
// Output bundle of the QPSK transmit shaper: enable in; shaped samples, symbol tap and phase out.
interface qpsk_tx_shaper_if #(
  parameter int NBT_OUT = 8,
  parameter int OS      = 4
);
  localparam int PW = (OS > 1) ? $clog2(OS) : 1;

  logic                      i_en_tx;
  logic signed [NBT_OUT-1:0] o_os_data_I;
  logic signed [NBT_OUT-1:0] o_os_data_Q;
  logic                      o_sym_I;
  logic                      o_sym_Q;
  logic                      o_sym_valid;
  logic [PW-1:0]             o_phase;

  modport master (
    input  i_en_tx,
    output o_os_data_I, o_os_data_Q, o_sym_I, o_sym_Q, o_sym_valid, o_phase
  );

  modport slave (
    output i_en_tx,
    input  o_os_data_I, o_os_data_Q, o_sym_I, o_sym_Q, o_sym_valid, o_phase
  );
endinterface

// File: rtl/qpsk_tx_shaper.sv
// QPSK transmit front end: PRBS9 symbols per branch, x OS upsampling, multiplier-free polyphase RRC FIR.
// Optional macro TX_PREAMBLE_EN: 16-symbol alternating preamble per branch before PRBS starts.
module qpsk_tx_branch #(
  parameter int                            OS       = 4,
  parameter int                            NUM_TAPS = 24,
  parameter int                            NBT_COEF = 8,
  parameter int                            NBF_COEF = 7,
  parameter logic [NUM_TAPS*NBT_COEF-1:0]  COEFS    = '0,
  parameter int                            NBT_OUT  = 8,
  parameter int                            NBF_OUT  = 7,
  parameter logic [8:0]                    SEED     = 9'h1AA,
  parameter int                            PW       = 2
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               ins_i,
  input  logic [PW-1:0]      ph_i,
  input  logic               pre_act_i,
  input  logic               pre_bit_i,
  output logic [NBT_OUT-1:0] data_o,
  output logic               sym_o
);
  localparam int L    = NUM_TAPS / OS;
  localparam int AW   = NBT_COEF + $clog2(L) + 1;
  localparam int SH   = NBF_COEF - NBF_OUT;
  localparam int SW   = AW + ((SH < 0) ? -SH : 0);
  localparam int MAXI = 2**(NBT_OUT-1) - 1;
  localparam logic signed [SW-1:0] MAXV = SW'(MAXI);
  localparam logic signed [SW-1:0] MINV = SW'(-MAXI);

  logic [8:0]         lfsr_q;
  logic [L-1:0]       sym_q, vld_q;
  logic               sym_out_q;
  logic [NBT_OUT-1:0] data_q, data_d;
  logic               new_bit;

  logic signed [AW-1:0]       acc;
  logic signed [AW-1:0]       cx;
  logic signed [NBT_COEF-1:0] c;
  logic signed [SW-1:0]       aligned;

  assign new_bit = pre_act_i ? pre_bit_i : lfsr_q[8];

  // Symbols are +-1, so each tap only adds or subtracts its coefficient.
  always_comb begin
    acc = '0;
    cx  = '0;
    c   = '0;
    for (int k = 0; k < L; k++) begin
      c  = COEFS[(k*OS + int'(ph_i))*NBT_COEF +: NBT_COEF];
      cx = {{(AW-NBT_COEF){c[NBT_COEF-1]}}, c};
      if (vld_q[k]) acc = sym_q[k] ? acc - cx : acc + cx;
    end
  end

  generate
    if (SH >= 0) begin : g_trunc
      assign aligned = acc >>> SH;
    end else begin : g_ext
      assign aligned = {acc, {(-SH){1'b0}}};
    end
  endgenerate

  // Symmetric clip keeps the most negative code out of the DAC stream.
  always_comb begin
    data_d = aligned[NBT_OUT-1:0];
    if (aligned > MAXV)      data_d = MAXV[NBT_OUT-1:0];
    else if (aligned < MINV) data_d = MINV[NBT_OUT-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      lfsr_q    <= SEED;
      sym_q     <= '0;
      vld_q     <= '0;
      sym_out_q <= 1'b0;
      data_q    <= '0;
    end else if (en_i) begin
      data_q <= data_d;
      if (ins_i) begin
        sym_q     <= {sym_q[L-2:0], new_bit};
        vld_q     <= {vld_q[L-2:0], 1'b1};
        sym_out_q <= new_bit;
        if (!pre_act_i) lfsr_q <= {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]};
      end
    end
  end

  assign data_o = data_q;
  assign sym_o  = sym_out_q;
endmodule

module qpsk_tx_shaper #(
  parameter int                           OS       = 4,
  parameter int                           NUM_TAPS = 24,
  parameter int                           NBT_COEF = 8,
  parameter int                           NBF_COEF = 7,
  parameter logic [NUM_TAPS*NBT_COEF-1:0] COEFS    = {
    8'hFF, 8'hFE, 8'h01, 8'h03, 8'h03, 8'hFE, 8'hF5, 8'hF2, 8'h00, 8'h1F, 8'h46, 8'h60,
    8'h60, 8'h46, 8'h1F, 8'h00, 8'hF2, 8'hF5, 8'hFE, 8'h03, 8'h03, 8'h01, 8'hFE, 8'hFF},
  parameter int                           NBT_OUT  = 8,
  parameter int                           NBF_OUT  = 7,
  parameter logic [8:0]                   SEED_I   = 9'h1AA,
  parameter logic [8:0]                   SEED_Q   = 9'h1FE
) (
  input  logic             clk,
  input  logic             i_reset,
  qpsk_tx_shaper_if.master tx
);
  localparam int PW = (OS > 1) ? $clog2(OS) : 1;

  logic [PW-1:0]             ph_q;
  logic                      sym_valid_q;
  logic                      ins;
  logic                      pre_act;
  logic [1:0]                pre_bits;
  logic [1:0][NBT_OUT-1:0]   data;
  logic [1:0]                sym;

  assign ins = tx.i_en_tx && (ph_q == PW'(OS-1));

  always_ff @(posedge clk) begin
    if (i_reset) begin
      ph_q        <= '0;
      sym_valid_q <= 1'b0;
    end else begin
      sym_valid_q <= ins;
      if (tx.i_en_tx) ph_q <= ins ? '0 : ph_q + PW'(1);
    end
  end

`ifdef TX_PREAMBLE_EN
  logic [4:0] pre_cnt_q;

  always_ff @(posedge clk) begin
    if (i_reset)             pre_cnt_q <= '0;
    else if (ins && pre_act) pre_cnt_q <= pre_cnt_q + 5'd1;
  end

  // I alternates every symbol, Q every two symbols.
  assign pre_act  = (pre_cnt_q < 5'd16);
  assign pre_bits = {pre_cnt_q[1], pre_cnt_q[0]};
`else
  assign pre_act  = 1'b0;
  assign pre_bits = 2'b00;
`endif

  generate
    for (genvar g = 0; g < 2; g++) begin : g_br
      qpsk_tx_branch #(
        .OS(OS), .NUM_TAPS(NUM_TAPS), .NBT_COEF(NBT_COEF), .NBF_COEF(NBF_COEF),
        .COEFS(COEFS), .NBT_OUT(NBT_OUT), .NBF_OUT(NBF_OUT),
        .SEED((g == 0) ? SEED_I : SEED_Q), .PW(PW)
      ) u_br (
        .clk      (clk),
        .rst_i    (i_reset),
        .en_i     (tx.i_en_tx),
        .ins_i    (ins),
        .ph_i     (ph_q),
        .pre_act_i(pre_act),
        .pre_bit_i(pre_bits[g]),
        .data_o   (data[g]),
        .sym_o    (sym[g])
      );
    end
  endgenerate

  assign tx.o_os_data_I = data[0];
  assign tx.o_os_data_Q = data[1];
  assign tx.o_sym_I     = sym[0];
  assign tx.o_sym_Q     = sym[1];
  assign tx.o_sym_valid = sym_valid_q;
  assign tx.o_phase     = ph_q;
endmodule
